// File: rtl/matrix_strip_arbiter_if.sv
// Bus between the strip arbiter and its two frame sources: requests, grant,
// per-client colours, pixel fetch and the serial LED strip lines.
interface matrix_strip_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        busy;
  logic        frame_done;
  logic [4:0]  bright;
  logic [23:0] fg0;
  logic [23:0] bg0;
  logic [23:0] fg1;
  logic [23:0] bg1;
  logic [5:0]  pix_addr;
  logic        pix_rd;
  logic        pix_bit0;
  logic        pix_bit1;
  logic        led_clk;
  logic        led_data;

  modport master (
    output req, bright, fg0, bg0, fg1, bg1, pix_bit0, pix_bit1,
    input  gnt, busy, frame_done, pix_addr, pix_rd, led_clk, led_data
  );

  modport slave (
    input  req, bright, fg0, bg0, fg1, bg1, pix_bit0, pix_bit1,
    output gnt, busy, frame_done, pix_addr, pix_rd, led_clk, led_data
  );
endinterface

// File: rtl/matrix_strip_arbiter.sv
// Grants one of two frame sources per frame and serialises a full APA102 8x8
// strip frame (start, 64 snake-mapped LED words, end) from its pixel bits.
module matrix_strip_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic                   clk,
  input logic                   reset,
  matrix_strip_arbiter_if.slave bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned LEDS   = 64;
  localparam logic [CNT_W-1:0] LAST_LED      = CNT_W'(LEDS - 1);
  localparam logic [CNT_W-1:0] LAST_WORD_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_END_BIT  = CNT_W'(2 * WORD_W - 1);
  // Strobe is registered on the edge leaving bit 29, so it is seen during bit 30.
  localparam logic [CNT_W-1:0] FETCH_BIT     = CNT_W'(WORD_W - 3);
  localparam logic [CNT_W-1:0] CAPTURE_BIT   = CNT_W'(WORD_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_PIX, S_END} state_t;

  state_t              state;
  logic                phase;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    led_idx;
  logic [WORD_W-2:0]   shreg;
  logic [4:0]          bright_q;
  logic [23:0]         fg_q;
  logic [23:0]         bg_q;
  logic                pix_sel;
  logic                last_gnt;

  logic                win_c;
  logic                fetch_c;
  logic                last_bit_c;
  logic [CNT_W-1:0]    next_led_c;
  logic [CNT_W-1:0]    snake_c;
  logic [WORD_W-1:0]   word_c;

  // Arbitration winner, fetch window, snake address of the next LED, LED word.
  always_comb begin
    win_c      = (bus.req == 2'b10) ||
                 ((bus.req == 2'b11) && !FIXED_PRIO && !last_gnt);
    fetch_c    = (state == S_START) || ((state == S_PIX) && (led_idx != LAST_LED));
    last_bit_c = (state == S_END) ? (bit_cnt == LAST_END_BIT) : (bit_cnt == LAST_WORD_BIT);
    next_led_c = (state == S_START) ? '0 : led_idx + CNT_W'(1);
    snake_c    = next_led_c[3] ? next_led_c : {next_led_c[5:3], ~next_led_c[2:0]};
    word_c     = {3'b111, bright_q, pix_sel ? fg_q : bg_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      phase          <= 1'b0;
      bit_cnt        <= '0;
      led_idx        <= '0;
      shreg          <= '0;
      bright_q       <= '0;
      fg_q           <= '0;
      bg_q           <= '0;
      pix_sel        <= 1'b0;
      last_gnt       <= 1'b1;
      bus.gnt        <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.pix_rd     <= 1'b0;
      bus.pix_addr   <= '0;
      bus.led_clk    <= 1'b0;
      bus.led_data   <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.pix_rd     <= 1'b0;
      if (state == S_IDLE) begin
        if (|bus.req) begin
          state    <= S_START;
          phase    <= 1'b0;
          bit_cnt  <= '0;
          led_idx  <= '0;
          last_gnt <= win_c;
          bus.gnt  <= win_c ? 2'b10 : 2'b01;
          bus.busy <= 1'b1;
          bright_q <= bus.bright;
          fg_q     <= win_c ? bus.fg1 : bus.fg0;
          bg_q     <= win_c ? bus.bg1 : bus.bg0;
        end
      end else if (!phase) begin
        phase       <= 1'b1;
        bus.led_clk <= 1'b1;
      end else begin
        phase       <= 1'b0;
        bus.led_clk <= 1'b0;
        if (fetch_c && (bit_cnt == FETCH_BIT)) begin
          bus.pix_rd   <= 1'b1;
          bus.pix_addr <= snake_c;
        end
        if (fetch_c && (bit_cnt == CAPTURE_BIT)) begin
          pix_sel <= bus.gnt[1] ? bus.pix_bit1 : bus.pix_bit0;
        end
        if (!last_bit_c) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (state == S_PIX) begin
            bus.led_data <= shreg[WORD_W-2];
            shreg        <= {shreg[WORD_W-3:0], 1'b0};
          end else begin
            bus.led_data <= 1'b0;
          end
        end else begin
          bit_cnt <= '0;
          case (state)
            S_START: begin
              state        <= S_PIX;
              led_idx      <= '0;
              bus.led_data <= word_c[WORD_W-1];
              shreg        <= word_c[WORD_W-2:0];
            end
            S_PIX: begin
              if (led_idx == LAST_LED) begin
                state        <= S_END;
                bus.led_data <= 1'b0;
              end else begin
                led_idx      <= led_idx + CNT_W'(1);
                bus.led_data <= word_c[WORD_W-1];
                shreg        <= word_c[WORD_W-2:0];
              end
            end
            default: begin
              state          <= S_IDLE;
              bus.gnt        <= '0;
              bus.busy       <= 1'b0;
              bus.frame_done <= 1'b1;
              bus.led_data   <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: doc/matrix_strip_arbiter.md
# matrix_strip_arbiter

Shares one APA102-style 8x8 LED matrix strip between two frame sources, such as the digit scroller and a status overlay. It grants one requester per frame and fetches one foreground/background bit per pixel from that requester, applying the snake-order row mapping. It serialises the complete strip frame (start frame, 64 LED words, end frame) onto `led_clk`/`led_data`, so the sources no longer generate strip timing themselves.

## Interface
- `FIXED_PRIO`, 0: 0 = round-robin between requesters; 1 = requester 0 always wins a tie.
- `clk`  in  1  system clock.
- `reset`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req`  in  2  frame request per client; level-sensitive.
- `gnt`  out  2  one-hot grant, held for the whole frame.
- `busy`  out  1  high while a frame is being sent.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `bright`  in  5  global brightness, latched at grant.
- `fg0`, `bg0`, `fg1`, `bg1`  in  24 each  per-client {B,G,R} colours, latched at grant.
- `pix_addr`  out  6  logical pixel index (row*8+col) requested from the granted client.
- `pix_rd`  out  1  one-cycle fetch strobe.
- `pix_bit0`, `pix_bit1`  in  1  pixel value from each client: 1 = foreground, 0 = background.
- `led_clk`  out  1  strip clock.
- `led_data`  out  1  strip data, MSB first.

## Operation
- States:
  - IDLE: send nothing; wait for a request.
  - START: send 32 zero bits.
  - PIX: send 64 LED words of 32 bits each.
  - END: send 64 zero bits.
  - Return to IDLE.
- Transitions:
  - IDLE with any `req` high → grant is decided at that edge → START.
  - The last END bit completes → IDLE.
- Arbitration:
  - Round-robin: the client that was not granted last wins a tie. After reset, client 0 wins the first tie.
  - A single requester always wins.
  - With `FIXED_PRIO`=1, client 0 wins every tie.
- A `req` drop mid-frame is ignored. The frame always completes, and `gnt` stays high until `frame_done`.
- At grant, latch `bright` and the granted client's fg/bg.
- LED word = {3'b111, bright, colour}, where colour = fg if the captured pixel bit is 1, else bg.
- Physical LED p (0..63): row r = p/8, column c = p%8.
  - `pix_addr` = r*8 + (7-c) for even r.
  - `pix_addr` = p for odd r.
- Pixel fetch for LED p:
  - `pix_rd` pulses in phase 0 of bit 30 of the preceding 32-bit frame. For p=0 that is the start frame; otherwise it is LED p-1.
  - `pix_addr` is valid in that cycle and held until the next `pix_rd`.
  - The granted client presents `pix_bitN` in the following cycle; the block registers it at the end of that cycle.
  - The word is loaded into the shift register for bit 0 of LED p.
  - There are exactly 64 `pix_rd` pulses per frame and none during LED 63.
- Reset is asynchronous and takes effect mid-frame:
  - The state goes to IDLE.
  - All outputs go to 0 immediately.
  - The round-robin pointer resets.

## Timing
- Reset values: `gnt`=0, `busy`=0, `frame_done`=0, `pix_rd`=0, `pix_addr`=0, `led_clk`=0, `led_data`=0.
- Each strip bit takes 2 cycles:
  - Phase 0: `led_clk`=0 and `led_data` updates.
  - Phase 1: `led_clk`=1 and `led_data` is stable.
- Cycle 0: `req` is sampled high in IDLE.
- Cycle 1: `gnt` and `busy` go high, and bit 0 of START is in phase 0.
- One frame is 32 + 2048 + 64 = 2144 bits, which is 4288 cycles (cycles 1..4288).
- Cycle 4289 (1-based from cycle 1): `frame_done`=1 while `gnt`=0, `busy`=0, `led_clk`=0, `led_data`=0, and the state is IDLE.
- With `req` still high at that edge, the next grant appears at cycle 4290. The minimum inter-frame gap is 1 idle cycle.
- `pix_rd` for LED 0 falls at START bit 30 phase 0, which is cycle 61.
- `pix_rd` for LED p≥1 falls at cycle 61 + 64p.

## Test plan
- Single requester: `req`=01, `pix_bit0`=1, `bright`=5'h1F, `fg0`=24'h0F000F.
  - Expect 32 zero bits.
  - Then expect 64 words of 32'hFF0F000F and 64 zero bits.
  - Expect 2144 `led_clk` rising edges and `frame_done` at cycle 4289.
- Snake mapping: log `pix_addr` at each `pix_rd` → 7,6,…,0, 8,…,15, 23,…,16, …, 56,…,63, with exactly 64 strobes.
- Fg/bg selection: `pix_bit1` = `pix_addr`[0], `fg1`=24'hFFFFFF, `bg1`=0, `bright`=5'h01.
  - LED 0 (addr 7) sends 32'hE1FFFFFF.
  - LED 1 (addr 6) sends 32'hE1000000.
- Round-robin: `req`=11 held continuously.
  - Expected grants: 01, 10, 01, 10.
  - Drop `req`[0] mid-frame: that frame still completes.
  - With `FIXED_PRIO`=1 the grant stays 01 every frame.
- Colour latching: change `fg0`/`bright` mid-frame → the rest of the frame is unchanged, and the new values apply from the next grant.
- Reset mid-PIX, at LED 20: assert `reset`=0 → all outputs are 0 in the same cycle. After release with `req`=10, client 1 is granted and a full 4288-cycle frame restarts from START.
